axi_mem_responder: RTL and testbench

Synthesizable AXI4 subordinate memory that answers the requests produced by the Renode-driven AXI manager, replacing the co-simulated memory with a native on-chip SRAM model. It sits on the manager's outgoing AXI request/response connection in the test harness and serves INCR bursts on independent read and write paths. The block is self-checking friendly: out-of-window accesses and malformed bursts are reported through BRESP/RRESP instead of corrupting memory.

---
 rtl/axi_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate SRAM model serving INCR bursts on independent read and write paths.
// Out-of-window bursts answer DECERR; a wlast/length disagreement answers SLVERR.
module axi_mem_responder #(
  parameter int          DATA_WIDTH = 64,
  parameter int          ID_WIDTH   = 4,
  parameter logic [31:0] MEM_BASE   = 32'h0000_1000,
  parameter int          MEM_BYTES  = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [31:0]             awaddr,
  input  logic [7:0]              awlen,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [31:0]             araddr,
  input  logic [7:0]              arlen,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast
);

  localparam int BPB   = DATA_WIDTH / 8;
  localparam int WORDS = MEM_BYTES / BPB;
  localparam int OFF_W = $clog2(BPB);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] addr);
    return IDX_W'((addr - MEM_BASE) >> OFF_W);
  endfunction

  // 33-bit span end so a burst running past 4 GiB cannot wrap back into the window.
  function automatic logic out_of_range(input logic [31:0] addr, input logic [7:0] len);
    logic [32:0] span_end;
    span_end = {1'b0, addr} - {1'b0, MEM_BASE} + ({25'd0, len} + 33'd1) * 33'(BPB);
    return (addr < MEM_BASE) || (span_end > 33'(MEM_BYTES));
  endfunction

  logic [DATA_WIDTH-1:0] mem [WORDS];

  w_state_t            w_state, w_next;
  logic [ID_WIDTH-1:0] w_id;
  logic [IDX_W-1:0]    w_idx;
  logic [7:0]          w_len, w_cnt;
  logic                w_decerr, w_slverr;

  r_state_t            r_state, r_next;
  logic [ID_WIDTH-1:0] r_id;
  logic [IDX_W-1:0]    r_idx;
  logic [7:0]          r_len, r_cnt;
  logic                r_err;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic aw_hs, w_hs, ar_hs, r_hs;
  logic ar_err;
  logic [IDX_W-1:0] ar_idx;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign ar_err = out_of_range(araddr, arlen);
  assign ar_idx = word_index(araddr);

  assign bid   = w_id;
  assign rid   = r_id;
  assign rdata = rdata_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = RESP_OKAY;
    unique case (w_state)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && (w_cnt == w_len)) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_decerr ? RESP_DECERR : (w_slverr ? RESP_SLVERR : RESP_OKAY);
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    rresp   = RESP_OKAY;
    rlast   = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_cnt == r_len);
        rresp  = r_err ? RESP_DECERR : RESP_OKAY;
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_id     <= '0;
      w_idx    <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_decerr <= 1'b0;
      w_slverr <= 1'b0;
    end else if (aw_hs) begin
      w_id     <= awid;
      w_idx    <= word_index(awaddr);
      w_len    <= awlen;
      w_cnt    <= '0;
      w_decerr <= out_of_range(awaddr, awlen);
      w_slverr <= 1'b0;
    end else if (w_hs) begin
      w_idx <= w_idx + 1'b1;
      w_cnt <= w_cnt + 8'd1;
      if (wlast != (w_cnt == w_len)) w_slverr <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; contents survive rst_ni and map onto plain SRAM.
  always_ff @(posedge clk_i) begin
    if (w_hs && !w_decerr) begin
      for (int b = 0; b < BPB; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // r_idx always points at the beat after the one held in rdata_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      rdata_q <= '0;
    end else if (ar_hs) begin
      r_id    <= arid;
      r_idx   <= ar_idx + 1'b1;
      r_len   <= arlen;
      r_cnt   <= '0;
      r_err   <= ar_err;
      rdata_q <= ar_err ? '0 : mem[ar_idx];
    end else if (r_hs && !rlast) begin
      r_idx   <= r_idx + 1'b1;
      r_cnt   <= r_cnt + 8'd1;
      rdata_q <= r_err ? '0 : mem[r_idx];
    end
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: stimulus tasks push expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents each response.
module tb_axi_mem_responder;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        rvalid, rready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  int checks = 0;
  int errors = 0;

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  logic [63:0] model [int];
  b_exp_t mon_b;
  r_exp_t mon_r;

  axi_mem_responder #(
    .DATA_WIDTH(64),
    .ID_WIDTH  (4),
    .MEM_BASE  (32'h0000_1000),
    .MEM_BYTES (4096)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .awvalid(awvalid),
    .awready(awready),
    .awid   (awid),
    .awaddr (awaddr),
    .awlen  (awlen),
    .wvalid (wvalid),
    .wready (wready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wlast  (wlast),
    .bvalid (bvalid),
    .bready (bready),
    .bid    (bid),
    .bresp  (bresp),
    .arvalid(arvalid),
    .arready(arready),
    .arid   (arid),
    .araddr (araddr),
    .arlen  (arlen),
    .rvalid (rvalid),
    .rready (rready),
    .rid    (rid),
    .rdata  (rdata),
    .rresp  (rresp),
    .rlast  (rlast)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_decerr(input logic [31:0] addr, input logic [7:0] len);
    longint span_end;
    span_end = longint'(addr) - 64'h1000 + (longint'(len) + 1) * 8;
    return (addr < 32'h1000) || (span_end > 4096);
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr - 32'h1000) >> 3);
  endfunction

  function automatic logic [63:0] model_rd(input int k);
    return model.exists(k) ? model[k] : 64'd0;
  endfunction

  function automatic void model_write(input int k, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] cur;
    cur = model_rd(k);
    for (int b = 0; b < 8; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    model[k] = cur;
  endfunction

  // Beat i carries data0+i; wlast is raised on beat last_beat (== len for a well-formed burst).
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                             input logic [63:0] data0, input logic [7:0] strb, input int last_beat);
    bit     dec;
    int     n;
    int     base;
    b_exp_t e;
    dec    = is_decerr(addr, len);
    e.id   = id;
    e.resp = dec ? 2'b11 : ((last_beat != int'(len)) ? 2'b10 : 2'b00);
    b_q.push_back(e);
    base = word_of(addr);
    @(posedge clk_i); #1;
    awvalid = 1'b1; awaddr = addr; awlen = len; awid = id;
    n = 0;
    @(negedge clk_i);
    while (!awready && n < 20) begin @(negedge clk_i); n++; end
    if (!awready) check("aw_timeout", awready, 1);
    @(posedge clk_i); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = data0 + 64'(i); wstrb = strb; wlast = (i == last_beat);
      n = 0;
      @(negedge clk_i);
      if (i == 0) check("wready_c1", wready, 1);
      while (!wready && n < 20) begin @(negedge clk_i); n++; end
      if (!wready) check("w_timeout", wready, 1);
      @(posedge clk_i); #1;
      if (!dec) model_write(base + i, data0 + 64'(i), strb);
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk_i);
    check("bvalid_c1", bvalid, 1);
    n = 0;
    do begin @(posedge clk_i); n++; end while (b_q.size() != 0 && n < 50);
    if (b_q.size() != 0) begin
      check("b_timeout", b_q.size(), 0);
      b_q.delete();
    end
    @(negedge clk_i);
    check("awready_back", awready, 1);
  endtask

  task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id);
    bit     dec;
    int     n;
    int     base;
    r_exp_t e;
    dec  = is_decerr(addr, len);
    base = word_of(addr);
    for (int i = 0; i <= int'(len); i++) begin
      e.id   = id;
      e.data = dec ? 64'd0 : model_rd(base + i);
      e.resp = dec ? 2'b11 : 2'b00;
      e.last = (i == int'(len));
      r_q.push_back(e);
    end
    @(posedge clk_i); #1;
    arvalid = 1'b1; araddr = addr; arlen = len; arid = id;
    n = 0;
    @(negedge clk_i);
    while (!arready && n < 20) begin @(negedge clk_i); n++; end
    if (!arready) check("ar_timeout", arready, 1);
    @(posedge clk_i); #1;
    arvalid = 1'b0;
  endtask

  // With toggle set, rready starts low on the first valid beat and alternates every cycle.
  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input bit toggle);
    int   n;
    logic rr;
    issue_ar(addr, len, id);
    rready = toggle ? 1'b0 : 1'b1;
    rr     = 1'b1;
    @(negedge clk_i);
    check("rvalid_c1", rvalid, 1);
    n = 0;
    do begin
      @(posedge clk_i); #1;
      if (toggle) begin rready = rr; rr = ~rr; end
      n++;
    end while (r_q.size() != 0 && n < 200);
    if (r_q.size() != 0) begin
      check("r_timeout", r_q.size(), 0);
      r_q.delete();
    end
    rready = 1'b0;
    @(negedge clk_i);
    check("arready_back", arready, 1);
    check("rvalid_idle", rvalid, 0);
  endtask

  // Scoreboard monitor: stalled R beats are compared against the head without popping.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (bvalid && bready) begin
        if (b_q.size() == 0) check("b_spurious", bvalid, 0);
        else begin
          mon_b = b_q.pop_front();
          check("bid", bid, mon_b.id);
          check("bresp", bresp, mon_b.resp);
        end
      end
      if (rvalid) begin
        if (r_q.size() == 0) check("r_spurious", rvalid, 0);
        else begin
          mon_r = r_q[0];
          check("rid", rid, mon_r.id);
          check("rdata", rdata, mon_r.data);
          check("rresp", rresp, mon_r.resp);
          check("rlast", rlast, mon_r.last);
          if (rready) void'(r_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_ni  = 1'b1;
    awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0;
    wvalid  = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0; arid = '0; araddr = '0; arlen = '0;
    rready  = 1'b0;

    #3 rst_ni = 1'b0;
    #1;
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_bid", bid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_arready", arready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rid", rid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rlast", rlast, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bready = 1'b1;

    // W beat offered before any AW must be held off.
    @(posedge clk_i); #1;
    wvalid = 1'b1; wdata = 64'hFFFF; wstrb = 8'hFF;
    @(negedge clk_i);
    check("w_before_aw", wready, 0);
    @(posedge clk_i); #1;
    wvalid = 1'b0;

    write_burst(32'h10C0, 8'd0, 4'd3, 64'h100, 8'hFF, 0);
    read_burst(32'h10C0, 8'd0, 4'd5, 1'b0);

    write_burst(32'h1000, 8'd0, 4'd1, 64'h11223344_55667788, 8'hFF, 0);
    write_burst(32'h1000, 8'd0, 4'd2, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 0);
    read_burst(32'h1000, 8'd0, 4'd4, 1'b0);

    write_burst(32'h1020, 8'd3, 4'd6, 64'd1, 8'hFF, 3);
    read_burst(32'h1020, 8'd3, 4'd7, 1'b1);

    read_burst(32'h2000, 8'd1, 4'd8, 1'b0);
    write_burst(32'h0FF8, 8'd1, 4'd9, 64'hDEAD_0000, 8'hFF, 1);
    write_burst(32'h1FF8, 8'd1, 4'd10, 64'hBEEF_0000, 8'hFF, 1);
    read_burst(32'h1000, 8'd0, 4'd11, 1'b0);

    write_burst(32'h1040, 8'd2, 4'd12, 64'h500, 8'hFF, 1);
    read_burst(32'h1040, 8'd2, 4'd13, 1'b0);

    // Reset while the second beat of a 4-beat read is stalled on the bus.
    issue_ar(32'h1020, 8'd3, 4'd14);
    rready = 1'b1;
    @(posedge clk_i); #1;
    rready = 1'b0;
    @(negedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    check("midrst_rvalid", rvalid, 0);
    check("midrst_arready", arready, 1);
    check("midrst_rlast", rlast, 0);
    check("midrst_rdata", rdata, 0);
    r_q.delete();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    read_burst(32'h1020, 8'd3, 4'd15, 1'b0);

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
